// File: rtl/phase_state_bank_pkg.sv
// Shared configuration for the phase state bank: sizes, LFSR setup, FSM states
// and lane-array types.
package phase_state_bank_pkg;

    localparam int NUM_LANES   = 4;
    localparam int LFSR_WIDTH  = 16;
    localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;
    localparam int PHASE_WIDTH = 6;
    localparam int SPIN_COUNT  = 64;
    localparam int ADDR_BITWIDTH = $clog2(SPIN_COUNT);

    typedef logic [PHASE_WIDTH-1:0]   phase_t;
    typedef logic [ADDR_BITWIDTH-1:0] spin_addr_t;
    typedef spin_addr_t [NUM_LANES-1:0] lane_addr_t;
    typedef phase_t     [NUM_LANES-1:0] lane_phase_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        DUMP = 2'd2
    } bank_state_t;

    // x^16 + x^14 + x^13 + x^11 + 1, shift left, feedback enters at bit 0
    function automatic logic [LFSR_WIDTH-1:0] lfsr_step(input logic [LFSR_WIDTH-1:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/phase_lfsr.sv
// 16-bit Fibonacci LFSR that supplies the random fill pattern; holds its value
// between fills so consecutive INITs continue the sequence.
module phase_lfsr
    import phase_state_bank_pkg::*;
#(
    parameter logic [LFSR_WIDTH-1:0] SEED = LFSR_SEED
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  advance,
    output logic [LFSR_WIDTH-1:0] value
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            value <= SEED;
        end else if (advance) begin
            value <= lfsr_step(value);
        end
    end

endmodule

// File: rtl/phase_state_bank.sv
// Flop-array bank of spin phases with multi-lane overwrite/accumulate updates,
// LFSR random fill and a backpressured sequential dump.
//
//   state | meaning
//   IDLE  | accepts update beats, waits for init_start / dump_start
//   INIT  | writes one LFSR-derived entry per cycle, addresses ascending
//   DUMP  | streams entries 0..NUM_SPINS-1 under dump_ready backpressure
module phase_state_bank #(
    parameter int          PHASE_BITWIDTH = 6,
    parameter int          NUM_SPINS      = 64,
    parameter int          NUM_LANES      = phase_state_bank_pkg::NUM_LANES,
    parameter logic [15:0] LFSR_SEED      = phase_state_bank_pkg::LFSR_SEED,
    localparam int         ADDR_W         = $clog2(NUM_SPINS)
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic                                     init_start,
    input  logic                                     dump_start,
    input  logic                                     upd_valid,
    output logic                                     upd_ready,
    input  logic                                     upd_mode,
    input  logic [NUM_LANES-1:0]                     upd_mask,
    input  logic [NUM_LANES-1:0][ADDR_W-1:0]         upd_addr,
    input  logic [NUM_LANES-1:0][PHASE_BITWIDTH-1:0] upd_phase,
    input  logic [ADDR_W-1:0]                        rd_addr,
    output logic [PHASE_BITWIDTH-1:0]                rd_phase,
    output logic                                     dump_valid,
    input  logic                                     dump_ready,
    output logic [ADDR_W-1:0]                        dump_addr,
    output logic [PHASE_BITWIDTH-1:0]                dump_phase,
    output logic                                     dump_last,
    output logic                                     init_done,
    output logic                                     busy
);

    import phase_state_bank_pkg::*;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_SPINS - 1);

    bank_state_t               state;
    bank_state_t               state_nxt;
    logic [ADDR_W-1:0]         cnt;
    logic [PHASE_BITWIDTH-1:0] mem [NUM_SPINS];
    logic [LFSR_WIDTH-1:0]     lfsr_value;
    logic                      lfsr_unused;
    logic                      init_wr;
    logic                      dump_fire;
    logic                      upd_fire;
    logic                      cnt_at_last;
    logic [NUM_LANES-1:0]      lane_win;

    phase_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .advance (init_wr),
        .value   (lfsr_value)
    );

    // Only the low bits feed the bank; the rest exist to keep the sequence long.
    assign lfsr_unused = ^lfsr_value[LFSR_WIDTH-1:PHASE_BITWIDTH];

    assign cnt_at_last = (cnt == LAST_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (init_start) begin
                    state_nxt = INIT;
                end else if (dump_start) begin
                    state_nxt = DUMP;
                end
            end
            INIT: begin
                if (cnt_at_last) begin
                    state_nxt = IDLE;
                end
            end
            DUMP: begin
                if (dump_ready && cnt_at_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        upd_ready  = (state == IDLE);
        busy       = (state != IDLE);
        dump_valid = (state == DUMP);
        dump_last  = (state == DUMP) && cnt_at_last;
        init_wr    = (state == INIT);
        dump_fire  = dump_valid && dump_ready;
        upd_fire   = upd_valid && upd_ready;
    end

    assign dump_addr  = cnt;
    assign dump_phase = mem[cnt];

    // A lane is dropped when any higher-index enabled lane hits the same address.
    always_comb begin
        for (int l = 0; l < NUM_LANES; l++) begin
            lane_win[l] = upd_mask[l];
            for (int j = 0; j < NUM_LANES; j++) begin
                if (j > l && upd_mask[j] && (upd_addr[j] == upd_addr[l])) begin
                    lane_win[l] = 1'b0;
                end
            end
        end
    end

    // Shared sweep counter; wraps to zero on the final INIT write or dump beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (init_wr || dump_fire) begin
            cnt <= cnt + 1'b1;
        end else if (state == IDLE) begin
            cnt <= '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            init_done <= 1'b0;
        end else begin
            init_done <= init_wr && cnt_at_last;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPINS; i++) begin
                mem[i] <= '0;
            end
        end else if (init_wr) begin
            mem[cnt] <= lfsr_value[PHASE_BITWIDTH-1:0];
        end else if (upd_fire) begin
            for (int l = 0; l < NUM_LANES; l++) begin
                if (lane_win[l]) begin
                    mem[upd_addr[l]] <= upd_mode ? (mem[upd_addr[l]] + upd_phase[l])
                                                 : upd_phase[l];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_phase <= '0;
        end else begin
            rd_phase <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_phase_state_bank.sv
// Randomized self-checking bench for phase_state_bank against a behavioural
// model of the bank contents and the LFSR fill sequence.
module tb_phase_state_bank;

    logic            clk = 1'b0;
    logic            rst;
    logic            init_start, dump_start;
    logic            upd_valid, upd_ready, upd_mode;
    logic [3:0]      upd_mask;
    logic [3:0][5:0] upd_addr;
    logic [3:0][5:0] upd_phase;
    logic [5:0]      rd_addr, rd_phase;
    logic            dump_valid, dump_ready, dump_last;
    logic [5:0]      dump_addr, dump_phase;
    logic            init_done, busy;

    int checks = 0;
    int errors = 0;

    logic [5:0]  model_mem [64];
    logic [5:0]  seen_mem  [64];
    logic [15:0] ref_lfsr;

    phase_state_bank dut (
        .clk        (clk),
        .rst        (rst),
        .init_start (init_start),
        .dump_start (dump_start),
        .upd_valid  (upd_valid),
        .upd_ready  (upd_ready),
        .upd_mode   (upd_mode),
        .upd_mask   (upd_mask),
        .upd_addr   (upd_addr),
        .upd_phase  (upd_phase),
        .rd_addr    (rd_addr),
        .rd_phase   (rd_phase),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_addr  (dump_addr),
        .dump_phase (dump_phase),
        .dump_last  (dump_last),
        .init_done  (init_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] ref_step(input logic [15:0] v);
        int   taps [4] = '{16, 14, 13, 11};
        logic fb = 1'b0;
        foreach (taps[k]) fb ^= v[taps[k] - 1];
        return {v[14:0], fb};
    endfunction

    function automatic void model_reset();
        ref_lfsr = 16'hACE1;
        foreach (model_mem[i]) model_mem[i] = 6'd0;
    endfunction

    function automatic void model_init();
        for (int i = 0; i < 64; i++) begin
            model_mem[i] = ref_lfsr[5:0];
            ref_lfsr = ref_step(ref_lfsr);
        end
    endfunction

    // Lanes applied in ascending order from a snapshot: the highest lane lands last.
    function automatic void model_beat(input logic mode, input logic [3:0] mask,
                                       input logic [3:0][5:0] a, input logic [3:0][5:0] p);
        logic [5:0] old [64];
        old = model_mem;
        for (int l = 0; l < 4; l++) begin
            if (mask[l]) model_mem[a[l]] = mode ? 6'((old[a[l]] + p[l]) % 64) : p[l];
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_entry(input int a, output logic [5:0] v);
        rd_addr = 6'(a);
        tick();
        v = rd_phase;
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) read_entry(i, seen_mem[i]);
    endtask

    task automatic send_beat(input logic mode, input logic [3:0] mask,
                             input logic [3:0][5:0] a, input logic [3:0][5:0] p);
        upd_mode  = mode;
        upd_mask  = mask;
        upd_addr  = a;
        upd_phase = p;
        upd_valid = 1'b1;
        tick();
        upd_valid = 1'b0;
        upd_mask  = 4'b0;
        model_beat(mode, mask, a, p);
    endtask

    task automatic run_init(output int busy_cycles, output int done_cycle);
        init_start = 1'b1;
        tick();
        init_start  = 1'b0;
        busy_cycles = 0;
        done_cycle  = 0;
        for (int c = 1; c <= 100; c++) begin
            if (busy) busy_cycles++;
            if (init_done) begin
                done_cycle = c;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2;
        checks++;
        if ({busy, dump_valid, init_done, upd_ready} !== 4'b0001) begin
            errors++;
            $display("FAIL reset_flags: busy/dump_valid/init_done/upd_ready got %b want 0001",
                     {busy, dump_valid, init_done, upd_ready});
        end
        checks++;
        if (rd_phase !== 6'd0) begin
            errors++;
            $display("FAIL reset_rd_phase: got %0d want 0", rd_phase);
        end
        tick();
        rst = 1'b0;
        model_reset();
        read_all();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (seen_mem[i] !== 6'd0) begin
                errors++;
                $display("FAIL reset_mem[%0d]: got %0d want 0", i, seen_mem[i]);
            end
        end
    endtask

    task automatic test_init();
        int bc, dc;
        model_init();
        run_init(bc, dc);
        checks++;
        if (bc != 64) begin
            errors++;
            $display("FAIL init_busy_cycles: got %0d want 64", bc);
        end
        checks++;
        if (dc != 65) begin
            errors++;
            $display("FAIL init_done_cycle: got %0d want 65", dc);
        end
        tick();
        checks++;
        if (init_done !== 1'b0) begin
            errors++;
            $display("FAIL init_done_width: got %b want 0 one cycle later", init_done);
        end
        read_all();
        checks++;
        if (seen_mem[0] !== 6'h21) begin
            errors++;
            $display("FAIL init_mem0: got %h want 21", seen_mem[0]);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (seen_mem[i] !== model_mem[i]) begin
                errors++;
                $display("FAIL init_mem[%0d]: got %h want %h", i, seen_mem[i], model_mem[i]);
            end
        end
    endtask

    task automatic test_accumulate();
        logic [3:0][5:0] a = '0;
        logic [3:0][5:0] p = '0;
        logic [5:0] v;
        a[0] = 6'd5;
        p[0] = 6'd60;
        send_beat(1'b0, 4'b0001, a, p);
        p[0] = 6'd10;
        send_beat(1'b1, 4'b0001, a, p);
        read_entry(5, v);
        checks++;
        if (v !== 6'd6) begin
            errors++;
            $display("FAIL accumulate_wrap: got %0d want 6", v);
        end
    endtask

    task automatic test_conflict();
        logic [3:0][5:0] a, p;
        logic [5:0] v;
        a = {6'd9, 6'd20, 6'd21, 6'd9};
        p = {6'd12, 6'd1, 6'd2, 6'd7};
        send_beat(1'b0, 4'b1001, a, p);
        read_entry(9, v);
        checks++;
        if (v !== 6'd12) begin
            errors++;
            $display("FAIL conflict_overwrite: got %0d want 12", v);
        end
        send_beat(1'b0, 4'b0001, a, p);
        read_entry(9, v);
        checks++;
        if (v !== 6'd7) begin
            errors++;
            $display("FAIL conflict_lane3_masked: got %0d want 7", v);
        end
        p = {6'd3, 6'd1, 6'd2, 6'd5};
        send_beat(1'b1, 4'b1001, a, p);
        read_entry(9, v);
        checks++;
        if (v !== 6'd10) begin
            errors++;
            $display("FAIL conflict_accumulate: got %0d want 10", v);
        end
    endtask

    task automatic test_random_updates();
        logic [3:0][5:0] a, p;
        logic [5:0] v;
        int ra;
        for (int n = 0; n < 60; n++) begin
            for (int l = 0; l < 4; l++) begin
                a[l] = 6'($urandom_range(0, 7));
                p[l] = 6'($urandom);
            end
            send_beat(1'($urandom), 4'($urandom), a, p);
            ra = $urandom_range(0, 7);
            read_entry(ra, v);
            checks++;
            if (v !== model_mem[ra]) begin
                errors++;
                $display("FAIL rand_update[%0d] addr %0d: got %0d want %0d", n, ra, v, model_mem[ra]);
            end
        end
        read_all();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (seen_mem[i] !== model_mem[i]) begin
                errors++;
                $display("FAIL rand_mem[%0d]: got %0d want %0d", i, seen_mem[i], model_mem[i]);
            end
        end
    endtask

    task automatic test_dump();
        int   exp_addr = 0;
        int   k = 0;
        logic exp_last;
        dump_start = 1'b1;
        tick();
        dump_start = 1'b0;
        while (exp_addr < 64 && k < 500) begin
            exp_last = (exp_addr == 63);
            checks++;
            if (dump_valid !== 1'b1 || dump_addr !== 6'(exp_addr) || dump_last !== exp_last) begin
                errors++;
                $display("FAIL dump_ctrl cycle %0d: valid %b addr %0d last %b want 1 %0d %b",
                         k, dump_valid, dump_addr, dump_last, exp_addr, exp_last);
            end
            checks++;
            if (dump_phase !== model_mem[exp_addr]) begin
                errors++;
                $display("FAIL dump_phase addr %0d: got %0d want %0d", exp_addr, dump_phase,
                         model_mem[exp_addr]);
            end
            dump_ready = (k < 3) ? (k != 1) : 1'($urandom_range(0, 1));
            tick();
            if (dump_ready) exp_addr++;
            k++;
        end
        dump_ready = 1'b0;
        checks++;
        if (exp_addr != 64) begin
            errors++;
            $display("FAIL dump_beats: got %0d want 64 within budget", exp_addr);
        end
        checks++;
        if (busy !== 1'b0 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL dump_return_idle: busy %b dump_valid %b want 0 0", busy, dump_valid);
        end
    endtask

    task automatic test_priority();
        logic seen_done = 1'b0;
        init_start = 1'b1;
        dump_start = 1'b1;
        tick();
        init_start = 1'b0;
        dump_start = 1'b0;
        checks++;
        if (busy !== 1'b1 || dump_valid !== 1'b0) begin
            errors++;
            $display("FAIL priority_init_wins: busy %b dump_valid %b want 1 0", busy, dump_valid);
        end
        model_init();
        for (int c = 1; c <= 100; c++) begin
            if (c == 10) begin
                upd_mode  = 1'b0;
                upd_mask  = 4'b1111;
                upd_addr  = {6'd3, 6'd2, 6'd1, 6'd0};
                upd_phase = {6'($urandom), 6'($urandom), 6'($urandom), 6'($urandom)};
                upd_valid = 1'b1;
                checks++;
                if (upd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL init_upd_ready: got %b want 0", upd_ready);
                end
            end
            if (c == 13) begin
                upd_valid = 1'b0;
                upd_mask  = 4'b0;
            end
            if (init_done) begin
                seen_done = 1'b1;
                break;
            end
            tick();
        end
        upd_valid = 1'b0;
        upd_mask  = 4'b0;
        checks++;
        if (seen_done !== 1'b1) begin
            errors++;
            $display("FAIL priority_init_done: got %b want 1 within budget", seen_done);
        end
        read_all();
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (seen_mem[i] !== model_mem[i]) begin
                errors++;
                $display("FAIL reinit_mem[%0d]: got %h want %h", i, seen_mem[i], model_mem[i]);
            end
        end
    endtask

    task automatic test_reset_mid_init();
        int bc, dc;
        init_start = 1'b1;
        tick();
        init_start = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL midinit_reset_async: busy %b init_done %b want 0 0", busy, init_done);
        end
        tick();
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) tick();
        checks++;
        if (upd_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL midinit_idle: upd_ready %b busy %b want 1 0", upd_ready, busy);
        end
        read_all();
        for (int i = 20; i < 64; i++) begin
            checks++;
            if (seen_mem[i] !== 6'd0) begin
                errors++;
                $display("FAIL midinit_mem[%0d]: got %h want 0", i, seen_mem[i]);
            end
        end
        model_init();
        run_init(bc, dc);
        checks++;
        if (dc != 65) begin
            errors++;
            $display("FAIL restart_done_cycle: got %0d want 65", dc);
        end
        tick();
        read_all();
        checks++;
        if (seen_mem[0] !== 6'h21) begin
            errors++;
            $display("FAIL restart_mem0: got %h want 21", seen_mem[0]);
        end
        for (int i = 0; i < 64; i++) begin
            checks++;
            if (seen_mem[i] !== model_mem[i]) begin
                errors++;
                $display("FAIL restart_mem[%0d]: got %h want %h", i, seen_mem[i], model_mem[i]);
            end
        end
    endtask

    initial begin
        rst        = 1'b1;
        init_start = 1'b0;
        dump_start = 1'b0;
        upd_valid  = 1'b0;
        upd_mode   = 1'b0;
        upd_mask   = 4'b0;
        upd_addr   = '0;
        upd_phase  = '0;
        rd_addr    = 6'd0;
        dump_ready = 1'b0;
        model_reset();

        test_reset();
        test_init();
        test_accumulate();
        test_conflict();
        test_random_updates();
        test_dump();
        test_priority();
        test_dump();
        test_reset_mid_init();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
